// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// hdmi_pkg : TMDS control/guard characters, TERC4 table, BCH step, packet types
// Revision : 1.0
// ============================================================================
package hdmi_pkg;

   localparam logic [9:0] CTRL_00    = 10'b1101010100;
   localparam logic [9:0] CTRL_01    = 10'b0010101011;
   localparam logic [9:0] CTRL_10    = 10'b0101010100;
   localparam logic [9:0] CTRL_11    = 10'b1010101011;
   localparam logic [9:0] GUARD_CHAR = 10'b0100110011;

   localparam logic [9:0] TERC4_TABLE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   localparam logic [7:0] BCH_POLY = 8'hC1;

   localparam logic [7:0] PKT_ACR          = 8'h01;
   localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
   localparam logic [7:0] PKT_AVI_IF       = 8'h82;
   localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PREAMBLE    = 3'd1,
      ST_GUARD_LEAD  = 3'd2,
      ST_PACKET      = 3'd3,
      ST_GUARD_TRAIL = 3'd4
   } island_state_t;

   function automatic logic [7:0] bch_step(input logic [7:0] code, input logic b);
      return {code[6:0], 1'b0} ^ ((code[7] ^ b) ? BCH_POLY : 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_terc4_decoder.sv
`default_nettype none
// ============================================================================
// hdmi_terc4_decoder : 10-bit TERC4 character to nibble, flags unknown codes
// Revision : 1.0
// ============================================================================
module hdmi_terc4_decoder
   import hdmi_pkg::*;
(
   input  logic [9:0] i_char,
   output logic [3:0] o_nibble,
   output logic       o_invalid
);

   always_comb begin
      o_nibble  = 4'h0;
      o_invalid = 1'b1;
      for (logic [4:0] k = 5'd0; k < 5'd16; k++) begin
         if (i_char == TERC4_TABLE[k[3:0]]) begin
            o_nibble  = k[3:0];
            o_invalid = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/hdmi_island_rx.sv
`default_nettype none
// ============================================================================
// hdmi_island_rx : data-island detector, TERC4 packet reassembly and BCH check
// Revision : 1.0
// ============================================================================
module hdmi_island_rx
   import hdmi_pkg::*;
#(
   parameter int MAX_PACKETS  = 18,
   parameter int PREAMBLE_LEN = 8
)(
   input  logic         pixclk,
   input  logic         rst_n,
   input  logic [9:0]   ch0_char,
   input  logic [9:0]   ch1_char,
   input  logic [9:0]   ch2_char,
   output logic         hsync,
   output logic         vsync,
   output logic         in_island,
   output logic         pkt_valid,
   output logic [23:0]  pkt_header,
   output logic [223:0] pkt_body,
   output logic         hdr_ok,
   output logic [3:0]   sub_ok,
   output logic         terc_err,
   output logic         island_err
);

   localparam int PCW = $clog2(PREAMBLE_LEN + 1);
   localparam int NW  = $clog2(MAX_PACKETS + 1);
   localparam logic [PCW-1:0] C_PRE_LEN = PCW'(PREAMBLE_LEN);
   localparam logic [NW-1:0]  C_MAX_PKT = NW'(MAX_PACKETS);

   logic [9:0]            r_ch0, r_ch1, r_ch2;
   island_state_t         r_state;
   logic [PCW-1:0]        r_pcnt;
   logic [4:0]            r_idx;
   logic [NW-1:0]         r_n;
   logic [23:0]           r_hdr;
   logic [27:0][3:0][1:0] r_sub;
   logic [7:0]            r_hlfsr;
   logic [3:0][7:0]       r_slfsr;
   logic                  r_terr;
   logic                  r_pend;

   logic [3:0]      w_d0, w_d1, w_d2;
   logic            w_inv0, w_inv1, w_inv2;
   logic            w_ctrl0;
   logic [1:0]      w_ctrl_sync;
   logic            w_preamble, w_guard, w_g0ok, w_d3_bad, w_terr_now;
   logic [7:0]      w_hl_next;
   logic [3:0][7:0] w_sl_next;
   logic [3:0][1:0] w_pair;
   logic [3:0]      w_sok;
   logic [223:0]    w_body;

   hdmi_terc4_decoder u_dec0 (.i_char(r_ch0), .o_nibble(w_d0), .o_invalid(w_inv0));
   hdmi_terc4_decoder u_dec1 (.i_char(r_ch1), .o_nibble(w_d1), .o_invalid(w_inv1));
   hdmi_terc4_decoder u_dec2 (.i_char(r_ch2), .o_nibble(w_d2), .o_invalid(w_inv2));

   always_comb begin
      w_ctrl0     = 1'b1;
      w_ctrl_sync = 2'b00;
      case (r_ch0)
         CTRL_00: w_ctrl_sync = 2'b00;
         CTRL_01: w_ctrl_sync = 2'b01;
         CTRL_10: w_ctrl_sync = 2'b10;
         CTRL_11: w_ctrl_sync = 2'b11;
         default: w_ctrl0     = 1'b0;
      endcase
   end

   assign w_preamble = (r_ch1 == CTRL_01) && (r_ch2 == CTRL_01);
   assign w_guard    = (r_ch1 == GUARD_CHAR) && (r_ch2 == GUARD_CHAR);
   assign w_g0ok     = !w_inv0 && (w_d0[3:2] == 2'b11);
   // Only the very first character of an island carries d0[3]=0.
   assign w_d3_bad   = (r_n == '0 && r_idx == 5'd0) ? w_d0[3] : ~w_d0[3];
   assign w_terr_now = w_inv0 | w_inv1 | w_inv2 | w_d3_bad;
   assign w_hl_next  = bch_step((r_idx == 5'd0) ? 8'h00 : r_hlfsr, w_d0[2]);

   for (genvar k = 0; k < 4; k++) begin : g_sub
      assign w_pair[k]    = {w_d2[k], w_d1[k]};
      assign w_sl_next[k] = bch_step(bch_step((r_idx == 5'd0) ? 8'h00 : r_slfsr[k],
                                              w_d1[k]), w_d2[k]);
      assign w_sok[k]     = (r_slfsr[k] == 8'h00);
      for (genvar i = 0; i < 28; i++) begin : g_bit
         assign w_body[56*k + 2*i +: 2] = r_sub[i][k];
      end
   end

   always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch0 <= '0; r_ch1 <= '0; r_ch2 <= '0;
         r_state <= ST_IDLE;
         r_pcnt <= '0; r_idx <= '0; r_n <= '0;
         r_hdr <= '0; r_sub <= '0; r_hlfsr <= '0; r_slfsr <= '0;
         r_terr <= 1'b0; r_pend <= 1'b0;
         hsync <= 1'b0; vsync <= 1'b0; in_island <= 1'b0;
         pkt_valid <= 1'b0; pkt_header <= '0; pkt_body <= '0;
         hdr_ok <= 1'b0; sub_ok <= '0; terc_err <= 1'b0; island_err <= 1'b0;
      end else begin
         r_ch0 <= ch0_char;
         r_ch1 <= ch1_char;
         r_ch2 <= ch2_char;

         // Completed packet is published one cycle after its last bit lands.
         pkt_valid <= r_pend;
         r_pend    <= 1'b0;
         if (r_pend) begin
            pkt_header <= r_hdr;
            pkt_body   <= w_body;
            hdr_ok     <= (r_hlfsr == 8'h00);
            sub_ok     <= w_sok;
            terc_err   <= r_terr;
         end

         if (w_ctrl0) begin
            {vsync, hsync} <= w_ctrl_sync;
         end else if (r_state != ST_IDLE) begin
            {vsync, hsync} <= w_d0[1:0];
         end

         island_err <= 1'b0;
         in_island  <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_preamble) begin
                  r_pcnt  <= PCW'(1);
                  r_state <= ST_PREAMBLE;
               end
            end
            ST_PREAMBLE: begin
               if (w_preamble) begin
                  if (r_pcnt < C_PRE_LEN) r_pcnt <= r_pcnt + 1'b1;
               end else if (r_pcnt < C_PRE_LEN) begin
                  r_state <= ST_IDLE;
               end else if (w_guard && w_g0ok) begin
                  r_state   <= ST_GUARD_LEAD;
                  in_island <= 1'b1;
               end else begin
                  r_state    <= ST_IDLE;
                  island_err <= 1'b1;
               end
            end
            ST_GUARD_LEAD: begin
               if (w_guard && w_g0ok) begin
                  r_state   <= ST_PACKET;
                  r_idx     <= 5'd0;
                  r_n       <= '0;
                  in_island <= 1'b1;
               end else begin
                  r_state    <= ST_IDLE;
                  island_err <= 1'b1;
               end
            end
            ST_PACKET: begin
               if (r_idx == 5'd0 && r_n != '0 && w_guard) begin
                  if (w_g0ok) begin
                     r_state   <= ST_GUARD_TRAIL;
                     in_island <= 1'b1;
                  end else begin
                     r_state    <= ST_IDLE;
                     island_err <= 1'b1;
                  end
               end else if (r_idx == 5'd0 && r_n >= C_MAX_PKT) begin
                  r_state    <= ST_IDLE;
                  island_err <= 1'b1;
               end else begin
                  in_island <= 1'b1;
                  r_hlfsr   <= w_hl_next;
                  r_slfsr   <= w_sl_next;
                  r_terr    <= (r_idx == 5'd0) ? w_terr_now : (r_terr | w_terr_now);
                  if (r_idx < 5'd24) r_hdr[r_idx] <= w_d0[2];
                  if (r_idx < 5'd28) r_sub[r_idx] <= w_pair;
                  r_idx <= r_idx + 5'd1;
                  if (r_idx == 5'd31) begin
                     r_n    <= r_n + 1'b1;
                     r_pend <= 1'b1;
                  end
               end
            end
            ST_GUARD_TRAIL: begin
               r_state <= ST_IDLE;
               if (w_guard && w_g0ok) begin
                  in_island <= 1'b1;
               end else begin
                  island_err <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_island_rx.sv
`default_nettype none
// ============================================================================
// tb_hdmi_island_rx : directed island streams with hand-derived expectations
// Revision : 1.0
// ============================================================================
module tb_hdmi_island_rx;

   logic         pixclk = 1'b0;
   logic         rst_n;
   logic [9:0]   ch0, ch1, ch2;
   logic         hsync, vsync, in_island, pkt_valid, hdr_ok, terc_err, island_err;
   logic [23:0]  pkt_header;
   logic [223:0] pkt_body;
   logic [3:0]   sub_ok;

   hdmi_island_rx dut (
      .pixclk(pixclk), .rst_n(rst_n),
      .ch0_char(ch0), .ch1_char(ch1), .ch2_char(ch2),
      .hsync(hsync), .vsync(vsync), .in_island(in_island),
      .pkt_valid(pkt_valid), .pkt_header(pkt_header), .pkt_body(pkt_body),
      .hdr_ok(hdr_ok), .sub_ok(sub_ok), .terc_err(terc_err), .island_err(island_err)
   );

   always #5 pixclk = ~pixclk;

   localparam logic [9:0] T4 [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };
   localparam logic [9:0] CTL [4] = '{10'b1101010100, 10'b0010101011,
                                      10'b0101010100, 10'b1010101011};
   localparam logic [9:0] GB = 10'b0100110011;

   localparam logic [55:0] ACR_SP = 56'h00100078690000;

   int n_checks = 0;
   int n_errors = 0;
   logic [1:0] g_hv = 2'b00;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Packet monitor
   int           n_valid, n_ierr, m_okcnt;
   logic [23:0]  m_hdr_q[$];
   logic [223:0] m_body;
   logic         m_hok, m_terr;
   logic [3:0]   m_sok;
   time          t_last, t_prev;

   always @(posedge pixclk) begin
      #1;
      if (pkt_valid === 1'b1) begin
         n_valid++;
         m_hdr_q.push_back(pkt_header);
         m_body = pkt_body;
         m_hok  = hdr_ok;
         m_sok  = sub_ok;
         m_terr = terc_err;
         if (hdr_ok && sub_ok == 4'hF && !terc_err) m_okcnt++;
         t_prev = t_last;
         t_last = $time;
      end
      if (island_err === 1'b1) n_ierr++;
   end

   task automatic clr();
      n_valid = 0; n_ierr = 0; m_okcnt = 0; m_hdr_q.delete();
      t_last = 0; t_prev = 0;
   endtask

   task automatic send(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
      @(negedge pixclk);
      ch0 = c0; ch1 = c1; ch2 = c2;
   endtask

   task automatic idle(input int n);
      repeat (n) send(CTL[g_hv], CTL[0], CTL[0]);
   endtask

   task automatic preamble(input int n);
      repeat (n) send(CTL[g_hv], CTL[1], CTL[1]);
   endtask

   task automatic guards();
      repeat (2) send(T4[{2'b11, g_hv}], GB, GB);
   endtask

   function automatic logic [7:0] bch(input logic [63:0] d, input int nb);
      logic [7:0] c = 8'h00;
      for (int i = 0; i < nb; i++)
         c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'hC1 : 8'h00);
      return c;
   endfunction

   task automatic send_packet(input logic [23:0] hb, input logic [3:0][55:0] sp,
                              input logic first, input int flip_hbit,
                              input int bad_ch1_i, input int d3_bad_i, input int stop_at);
      logic [7:0]       par;
      logic [31:0]      h32;
      logic [3:0][63:0] s64;
      logic [3:0]       d0, d1, d2;
      logic [9:0]       c1;
      par = bch({40'h0, hb}, 24);
      h32[23:0] = hb;
      for (int j = 0; j < 8; j++) h32[24+j] = par[7-j];
      if (flip_hbit >= 0) h32[flip_hbit] = ~h32[flip_hbit];
      for (int k = 0; k < 4; k++) begin
         par = bch({8'h0, sp[k]}, 56);
         s64[k][55:0] = sp[k];
         for (int j = 0; j < 8; j++) s64[k][56+j] = par[7-j];
      end
      for (int i = 0; i < 32; i++) begin
         if (i == stop_at) return;
         d0 = {!(first && i == 0), h32[i], g_hv};
         if (i == d3_bad_i) d0[3] = ~d0[3];
         for (int k = 0; k < 4; k++) begin
            d1[k] = s64[k][2*i];
            d2[k] = s64[k][2*i+1];
         end
         c1 = (i == bad_ch1_i) ? 10'h000 : T4[d1];
         send(T4[d0], c1, T4[d2]);
      end
   endtask

   task automatic acr_island(input int npre);
      preamble(npre);
      guards();
      send_packet(24'h000001, {4{ACR_SP}}, 1'b1, -1, -1, -1, 99);
      guards();
      idle(6);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      ch0 = CTL[0]; ch1 = CTL[0]; ch2 = CTL[0];
      clr();
      repeat (3) @(negedge pixclk);
      chk("reset_valid", pkt_valid, 1'b0);
      chk("reset_island", in_island, 1'b0);
      chk("reset_sync", {vsync, hsync}, 2'b00);
      chk("reset_hdr", pkt_header, 24'h0);
      chk("reset_ierr", island_err, 1'b0);
      rst_n = 1'b1;
      idle(4);

      // hsync appears two edges after its character is sampled
      g_hv = 2'b01;
      idle(2);
      chk("hsync_lag_early", hsync, 1'b0);
      idle(1);
      chk("hsync_lag", hsync, 1'b1);
      g_hv = 2'b00;
      idle(4);
      chk("sync_idle", {vsync, hsync}, 2'b00);

      // ACR island with exact pkt_valid latency
      clr();
      g_hv = 2'b10;
      preamble(8);
      guards();
      send_packet(24'h000001, {4{ACR_SP}}, 1'b1, -1, -1, -1, 99);
      chk("island_mid", in_island, 1'b1);
      chk("vsync_island", vsync, 1'b1);
      send(T4[{2'b11, g_hv}], GB, GB);
      chk("acr_lat1", pkt_valid, 1'b0);
      send(T4[{2'b11, g_hv}], GB, GB);
      chk("acr_lat2", pkt_valid, 1'b0);
      idle(1);
      chk("acr_lat3", pkt_valid, 1'b1);
      idle(5);
      chk("island_after", in_island, 1'b0);
      chk("acr_count", n_valid, 1);
      chk("acr_hdr", m_hdr_q[0], 24'h000001);
      chk("acr_body", m_body, {4{ACR_SP}});
      chk("acr_hok", m_hok, 1'b1);
      chk("acr_sok", m_sok, 4'hF);
      chk("acr_terr", m_terr, 1'b0);
      chk("acr_ierr", n_ierr, 0);
      chk("hold_hdr", pkt_header, 24'h000001);
      g_hv = 2'b00;

      // Two back-to-back packets
      clr();
      preamble(8);
      guards();
      send_packet(24'h0A0184, {56'h0, 56'h0, 56'h0, 56'h00000000001160}, 1'b1, -1, -1, -1, 99);
      send_packet(24'h000F02, {4{56'h0}}, 1'b0, -1, -1, -1, 99);
      guards();
      idle(6);
      chk("two_count", n_valid, 2);
      chk("two_ok", m_okcnt, 2);
      chk("two_hdr0", m_hdr_q[0], 24'h0A0184);
      chk("two_hdr1", m_hdr_q[1], 24'h000F02);
      chk("two_gap", t_last - t_prev, 320);
      chk("two_ierr", n_ierr, 0);

      // Header bit 5 flipped
      clr();
      preamble(8);
      guards();
      send_packet(24'h000001, {4{ACR_SP}}, 1'b1, 5, -1, -1, 99);
      guards();
      idle(6);
      chk("flip_hdr", m_hdr_q[0], 24'h000021);
      chk("flip_hok", m_hok, 1'b0);
      chk("flip_sok", m_sok, 4'hF);

      // Short preamble ignored, longer one accepted
      clr();
      acr_island(7);
      chk("pre7_valid", n_valid, 0);
      chk("pre7_ierr", n_ierr, 0);
      clr();
      acr_island(9);
      chk("pre9_valid", n_valid, 1);
      chk("pre9_ok", m_okcnt, 1);

      // TERC4 errors
      clr();
      preamble(8);
      guards();
      send_packet(24'h000001, {4{ACR_SP}}, 1'b1, -1, 10, -1, 99);
      guards();
      idle(6);
      chk("bad_ch1_terr", m_terr, 1'b1);
      clr();
      preamble(8);
      guards();
      send_packet(24'h000001, {4{ACR_SP}}, 1'b1, -1, -1, 5, 99);
      guards();
      idle(6);
      chk("d3_terr", m_terr, 1'b1);
      chk("d3_hok", m_hok, 1'b1);

      // Protocol aborts
      clr();
      preamble(8);
      send(T4[{2'b10, g_hv}], GB, GB);
      idle(4);
      chk("lead_bad_ierr", n_ierr, 1);
      clr();
      preamble(8);
      idle(4);
      chk("no_guard_ierr", n_ierr, 1);
      chk("no_guard_valid", n_valid, 0);

      // Packet limit
      clr();
      preamble(8);
      guards();
      for (int p = 0; p < 18; p++)
         send_packet(24'h000002, {4{56'h0}}, p == 0, -1, -1, -1, 99);
      send_packet(24'h000002, {4{56'h0}}, 1'b0, -1, -1, -1, 1);
      idle(6);
      chk("max_valid", n_valid, 18);
      chk("max_ok", m_okcnt, 18);
      chk("max_ierr", n_ierr, 1);

      // Reset mid-packet
      clr();
      g_hv = 2'b11;
      preamble(8);
      guards();
      send_packet(24'h000001, {4{ACR_SP}}, 1'b1, -1, -1, -1, 20);
      @(negedge pixclk);
      rst_n = 1'b0;
      #1;
      chk("rst_island", in_island, 1'b0);
      chk("rst_sync", {vsync, hsync}, 2'b00);
      chk("rst_hdr", pkt_header, 24'h0);
      repeat (2) @(negedge pixclk);
      rst_n = 1'b1;
      g_hv = 2'b00;
      idle(6);
      chk("rst_novalid", n_valid, 0);
      clr();
      acr_island(8);
      chk("post_rst_valid", n_valid, 1);
      chk("post_rst_ok", m_okcnt, 1);
      chk("post_rst_hdr", m_hdr_q[0], 24'h000001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
